// File: rtl/pc_target_table.sv
// ============================================================================
// pc_target_table
// ----------------------------------------------------------------------------
// Programmable branch-target table for the fetch stage. DEPTH entries of D-bit
// targets, each with a valid bit. After reset the table runs an init sweep
// (one entry per cycle, DEPTH cycles) that zeroes the stored data; during the
// sweep every request is dropped. Once the sweep finishes, the table accepts
// writes, invalidates and lookups. A lookup returns its result one cycle later
// as a registered target/hit pair with a one-cycle target_valid pulse. A miss
// returns target 0, which the PC mux treats as "hold PC".
//
// Same-cycle interactions, in order of priority:
//   write + invalidate, same index  -> the write wins
//   lookup + write, same index      -> lookup sees the new data with a hit
//   lookup + invalidate, same index -> lookup misses
//
// Optional feature (macro PC_TARGET_REL_EN):
//   Adds pc_in and wr_rel. Each entry also stores a relative-mode bit. A hit on
//   a relative entry returns pc_in + entry (mod 2^D), with pc_in taken in the
//   same cycle as the request.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   ready        out  high once the init sweep has completed
//   lookup_req   in   lookup request
//   lookup_addr  in   [A-1:0] lookup index
//   target       out  [D-1:0] registered lookup result (0 on miss)
//   target_valid out  pulse: target/hit belong to the previous-cycle request
//   hit          out  looked-up entry was valid
//   wr_en        in   write enable (also sets the entry valid)
//   wr_addr      in   [A-1:0] write index
//   wr_data      in   [D-1:0] write data
//   inv_en       in   invalidate enable
//   inv_addr     in   [A-1:0] invalidate index
//   pc_in        in   [D-1:0] base PC for relative entries (macro only)
//   wr_rel       in   relative-mode bit for the written entry (macro only)
//   valid_count  out  [A:0] number of valid entries, 0..DEPTH
// ============================================================================
module pc_target_table #(
    parameter  int D     = 12,
    parameter  int DEPTH = 32,
    localparam int A     = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    output logic         ready,
    input  logic         lookup_req,
    input  logic [A-1:0] lookup_addr,
    output logic [D-1:0] target,
    output logic         target_valid,
    output logic         hit,
    input  logic         wr_en,
    input  logic [A-1:0] wr_addr,
    input  logic [D-1:0] wr_data,
    input  logic         inv_en,
    input  logic [A-1:0] inv_addr,
`ifdef PC_TARGET_REL_EN
    input  logic [D-1:0] pc_in,
    input  logic         wr_rel,
`endif
    output logic [A:0]   valid_count
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [A-1:0]     r_init_idx;
    logic [A-1:0]     w_init_idx_next;

    logic [D-1:0]     r_entry [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] w_valid_next;
    logic [A:0]       r_count;

    logic [D-1:0]     r_target;
    logic             r_hit;
    logic             r_target_valid;

    logic             w_run;
    logic             w_wr;
    logic             w_inv;
    logic             w_cnt_inc;
    logic             w_cnt_dec;

    logic             w_fwd;
    logic             w_lookup_hit;
    logic [D-1:0]     w_lookup_data;
    logic [D-1:0]     w_lookup_target;

`ifdef PC_TARGET_REL_EN
    logic [DEPTH-1:0] r_rel;
    logic             w_lookup_rel;
`endif

    // ------------------------------------------------------------------------
    // Control FSM: INIT sweeps every index once, then RUN until reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_INIT;
            r_init_idx <= '0;
        end else begin
            r_state    <= w_state_next;
            r_init_idx <= w_init_idx_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_init_idx_next = r_init_idx;
        ready           = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_init_idx_next = r_init_idx + A'(1);
                if (r_init_idx == A'(DEPTH - 1)) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                ready = 1'b1;
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    // Requests only have an effect once the sweep is over.
    assign w_run = (r_state == ST_RUN);
    assign w_wr  = w_run & wr_en;
    assign w_inv = w_run & inv_en;

    // ------------------------------------------------------------------------
    // Entry storage. Not reset: the init sweep zeroes it, which keeps the
    // array mappable onto RAM. The relative-mode bits share the write path.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_entry[r_init_idx] <= '0;
`ifdef PC_TARGET_REL_EN
            r_rel[r_init_idx]   <= 1'b0;
`endif
        end else if (wr_en) begin
            r_entry[wr_addr]    <= wr_data;
`ifdef PC_TARGET_REL_EN
            r_rel[wr_addr]      <= wr_rel;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Valid bits: write has priority over invalidate on the same index.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
        assign w_valid_next[gi] = (w_wr  && wr_addr  == A'(gi)) ? 1'b1 :
                                  (w_inv && inv_addr == A'(gi)) ? 1'b0 :
                                  r_valid[gi];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else begin
            r_valid <= w_valid_next;
        end
    end

    // Count tracks transitions rather than re-counting the vector. An
    // invalidate that collides with a same-index write is cancelled, so it
    // must not decrement.
    assign w_cnt_inc = w_wr & ~r_valid[wr_addr];
    assign w_cnt_dec = w_inv & r_valid[inv_addr] & ~(w_wr && (wr_addr == inv_addr));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + (A+1)'(w_cnt_inc) - (A+1)'(w_cnt_dec);
        end
    end

    // ------------------------------------------------------------------------
    // Lookup path with write-first forwarding.
    // ------------------------------------------------------------------------
    always_comb begin
        w_fwd         = wr_en && (wr_addr == lookup_addr);
        w_lookup_hit  = w_fwd |
                        (r_valid[lookup_addr] & ~(inv_en && (inv_addr == lookup_addr)));
        w_lookup_data = w_fwd ? wr_data : r_entry[lookup_addr];
`ifdef PC_TARGET_REL_EN
        w_lookup_rel  = w_fwd ? wr_rel : r_rel[lookup_addr];
        // Offset add wraps modulo 2^D by truncation.
        w_lookup_target = w_lookup_rel ? (pc_in + w_lookup_data) : w_lookup_data;
`else
        w_lookup_target = w_lookup_data;
`endif
        if (!w_lookup_hit) begin
            w_lookup_target = '0;
        end
    end

    // Result registers: target/hit hold between requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_target       <= '0;
            r_hit          <= 1'b0;
            r_target_valid <= 1'b0;
        end else begin
            r_target_valid <= w_run & lookup_req;
            if (w_run && lookup_req) begin
                r_target <= w_lookup_target;
                r_hit    <= w_lookup_hit;
            end
        end
    end

    assign target       = r_target;
    assign hit          = r_hit;
    assign target_valid = r_target_valid;
    assign valid_count  = r_count;

endmodule

// File: tb/tb_pc_target_table.sv
module tb_pc_target_table;

    localparam int D     = 12;
    localparam int DEPTH = 32;
    localparam int A     = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic         ready;
    logic         lookup_req;
    logic [A-1:0] lookup_addr;
    logic [D-1:0] target;
    logic         target_valid;
    logic         hit;
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [D-1:0] wr_data;
    logic         inv_en;
    logic [A-1:0] inv_addr;
    logic [D-1:0] pc_in;
    logic         wr_rel;
    logic [A:0]   valid_count;

    int checks   = 0;
    int failures = 0;

    pc_target_table #(.D(D), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .ready        (ready),
        .lookup_req   (lookup_req),
        .lookup_addr  (lookup_addr),
        .target       (target),
        .target_valid (target_valid),
        .hit          (hit),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .inv_en       (inv_en),
        .inv_addr     (inv_addr),
`ifdef PC_TARGET_REL_EN
        .pc_in        (pc_in),
        .wr_rel       (wr_rel),
`endif
        .valid_count  (valid_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [D-1:0] m_data  [DEPTH];
    bit           m_valid [DEPTH];
    bit           m_rel   [DEPTH];
    bit           m_run;
    int           m_init_left;
    bit           e_tv;
    bit           e_hit;
    logic [D-1:0] e_target;

    function automatic int model_count();
        int n = 0;
        foreach (m_valid[i]) n += int'(m_valid[i]);
        return n;
    endfunction

    task automatic model_reset();
        m_run       = 1'b0;
        m_init_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i]  = '0;
            m_valid[i] = 1'b0;
            m_rel[i]   = 1'b0;
        end
        e_tv     = 1'b0;
        e_hit    = 1'b0;
        e_target = '0;
    endtask

    task automatic idle();
        lookup_req  = 1'b0;
        lookup_addr = '0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        inv_en      = 1'b0;
        inv_addr    = '0;
        pc_in       = '0;
        wr_rel      = 1'b0;
    endtask

    // One clock edge: model consumes the inputs present at the edge, then
    // time advances 1 unit so DUT outputs can be sampled.
    task automatic tick();
        bit           v;
        bit           r;
        logic [D-1:0] d;
        @(posedge clk);
        if (m_run && lookup_req) begin
            if (wr_en && wr_addr == lookup_addr) begin
                v = 1'b1; d = wr_data; r = wr_rel;
            end else begin
                v = m_valid[lookup_addr] && !(inv_en && inv_addr == lookup_addr);
                d = m_data[lookup_addr];
                r = m_rel[lookup_addr];
            end
            e_tv  = 1'b1;
            e_hit = v;
            if (!v)     e_target = '0;
            else if (r) e_target = pc_in + d;
            else        e_target = d;
        end else begin
            e_tv = 1'b0;
        end
        if (m_run) begin
            if (inv_en) m_valid[inv_addr] = 1'b0;
            if (wr_en) begin
                m_data[wr_addr]  = wr_data;
                m_valid[wr_addr] = 1'b1;
                m_rel[wr_addr]   = wr_rel;
            end
        end else begin
            m_init_left--;
            if (m_init_left == 0) m_run = 1'b1;
        end
        #1;
    endtask

    // Assert reset across one edge, check outputs, release, sweep with junk
    // requests and check ready timing.
    task automatic test_reset();
        idle();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0b exp=0", ready); end
        checks++; if (target_valid !== 1'b0) begin failures++; $display("FAIL rst_tv got=%0b exp=0", target_valid); end
        checks++; if (hit !== 1'b0) begin failures++; $display("FAIL rst_hit got=%0b exp=0", hit); end
        checks++; if (target !== '0) begin failures++; $display("FAIL rst_target got=%0h exp=0", target); end
        checks++; if (valid_count !== '0) begin failures++; $display("FAIL rst_count got=%0d exp=0", valid_count); end
        reset = 1'b0;
        for (int c = 0; c < DEPTH; c++) begin
            lookup_req  = 1'($urandom_range(0, 1));
            lookup_addr = A'($urandom);
            wr_en       = 1'($urandom_range(0, 1));
            wr_addr     = A'($urandom);
            wr_data     = D'($urandom);
            inv_en      = 1'($urandom_range(0, 1));
            inv_addr    = A'($urandom);
            tick();
            $display("init cycle %0d ready=%0b tv=%0b count=%0d", c, ready, target_valid, valid_count);
            checks++; if (ready !== m_run) begin failures++; $display("FAIL init_ready cyc=%0d got=%0b exp=%0b", c, ready, m_run); end
            checks++; if (target_valid !== 1'b0) begin failures++; $display("FAIL init_tv cyc=%0d got=%0b exp=0", c, target_valid); end
            checks++; if (valid_count !== '0) begin failures++; $display("FAIL init_count cyc=%0d got=%0d exp=0", c, valid_count); end
        end
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            lookup_req  = 1'b1;
            lookup_addr = A'(i);
            tick();
            $display("empty lookup idx=%0d tv=%0b hit=%0b target=%0h", i, target_valid, hit, target);
            checks++; if (target_valid !== 1'b1) begin failures++; $display("FAIL empty_tv idx=%0d got=%0b exp=1", i, target_valid); end
            checks++; if (hit !== 1'b0 || target !== '0) begin failures++; $display("FAIL empty_lookup idx=%0d got hit=%0b target=%0h exp hit=0 target=0", i, hit, target); end
        end
        idle();
        tick();
        checks++; if (valid_count !== '0) begin failures++; $display("FAIL empty_count got=%0d exp=0", valid_count); end
    endtask

    task automatic test_write_lookup();
        int           idx  [4] = '{0, 1, 16, 1};
        int           dat  [4] = '{10, 30, 141, 39};
        int           cnt  [4] = '{1, 2, 3, 3};
        for (int k = 0; k < 4; k++) begin
            idle();
            wr_en = 1'b1; wr_addr = A'(idx[k]); wr_data = D'(dat[k]);
            tick();
            $display("write idx=%0d data=%0d count=%0d", idx[k], dat[k], valid_count);
            checks++; if (valid_count !== (A+1)'(cnt[k])) begin failures++; $display("FAIL wr_count idx=%0d got=%0d exp=%0d", idx[k], valid_count, cnt[k]); end
        end
        for (int k = 0; k < 4; k++) begin
            if (k == 1) continue;  // idx1 was rewritten; k=3 covers it
            idle();
            lookup_req = 1'b1; lookup_addr = A'(idx[k]);
            tick();
            $display("lookup idx=%0d tv=%0b hit=%0b target=%0d", idx[k], target_valid, hit, target);
            checks++; if (target_valid !== 1'b1 || hit !== 1'b1 || target !== D'(dat[k])) begin
                failures++; $display("FAIL wr_lookup idx=%0d got tv=%0b hit=%0b target=%0d exp tv=1 hit=1 target=%0d", idx[k], target_valid, hit, target, dat[k]);
            end
            idle();
            tick();
            checks++; if (target_valid !== 1'b0 || target !== D'(dat[k]) || hit !== 1'b1) begin
                failures++; $display("FAIL hold idx=%0d got tv=%0b hit=%0b target=%0d exp tv=0 hit=1 target=%0d", idx[k], target_valid, hit, target, dat[k]);
            end
        end
    endtask

    task automatic test_forwarding();
        idle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 12'd61;
        lookup_req = 1'b1; lookup_addr = 5'd5;
        tick();
        $display("fwd write+lookup idx=5 hit=%0b target=%0d count=%0d", hit, target, valid_count);
        checks++; if (target_valid !== 1'b1 || hit !== 1'b1 || target !== 12'd61) begin
            failures++; $display("FAIL fwd_wr got tv=%0b hit=%0b target=%0d exp tv=1 hit=1 target=61", target_valid, hit, target);
        end
        checks++; if (valid_count !== 6'd4) begin failures++; $display("FAIL fwd_count got=%0d exp=4", valid_count); end
        idle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 12'd62;
        inv_en = 1'b1; inv_addr = 5'd5;
        tick();
        checks++; if (valid_count !== 6'd4) begin failures++; $display("FAIL wr_inv_count got=%0d exp=4", valid_count); end
        idle();
        lookup_req = 1'b1; lookup_addr = 5'd5;
        tick();
        $display("after write+inv idx=5 hit=%0b target=%0d", hit, target);
        checks++; if (hit !== 1'b1 || target !== 12'd62) begin failures++; $display("FAIL wr_inv_lookup got hit=%0b target=%0d exp hit=1 target=62", hit, target); end
        idle();
        lookup_req = 1'b1; lookup_addr = 5'd5;
        inv_en = 1'b1; inv_addr = 5'd5;
        tick();
        $display("lookup+inv idx=5 hit=%0b target=%0d count=%0d", hit, target, valid_count);
        checks++; if (hit !== 1'b0 || target !== '0) begin failures++; $display("FAIL lk_inv got hit=%0b target=%0d exp hit=0 target=0", hit, target); end
        checks++; if (valid_count !== 6'd3) begin failures++; $display("FAIL lk_inv_count got=%0d exp=3", valid_count); end
    endtask

    task automatic test_fill_invalidate();
        logic [D-1:0] dat [DEPTH];
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            dat[i] = D'($urandom);
            wr_en = 1'b1; wr_addr = A'(i); wr_data = dat[i];
            tick();
        end
        $display("fill count=%0d", valid_count);
        checks++; if (valid_count !== 6'd32) begin failures++; $display("FAIL fill_count got=%0d exp=32", valid_count); end
        for (int k = 0; k < 3; k++) begin
            idle();
            inv_en = 1'b1; inv_addr = 5'd0;
            tick();
            $display("invalidate idx=0 pass=%0d count=%0d", k, valid_count);
            checks++; if (valid_count !== 6'd31) begin failures++; $display("FAIL inv_count pass=%0d got=%0d exp=31", k, valid_count); end
        end
        idle();
        lookup_req = 1'b1; lookup_addr = 5'd0;
        tick();
        lookup_addr = 5'd31;
        checks++; if (target_valid !== 1'b1 || hit !== 1'b0 || target !== '0) begin
            failures++; $display("FAIL b2b_idx0 got tv=%0b hit=%0b target=%0h exp tv=1 hit=0 target=0", target_valid, hit, target);
        end
        tick();
        $display("b2b idx31 tv=%0b hit=%0b target=%0h", target_valid, hit, target);
        checks++; if (target_valid !== 1'b1 || hit !== 1'b1 || target !== dat[31]) begin
            failures++; $display("FAIL b2b_idx31 got tv=%0b hit=%0b target=%0h exp tv=1 hit=1 target=%0h", target_valid, hit, target, dat[31]);
        end
        idle();
        tick();
        checks++; if (target_valid !== 1'b0) begin failures++; $display("FAIL b2b_end_tv got=%0b exp=0", target_valid); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            lookup_req  = ($urandom_range(0, 9) < 7);
            lookup_addr = ($urandom_range(0, 1) != 0) ? A'($urandom_range(0, 3)) : A'($urandom);
            wr_en       = ($urandom_range(0, 9) < 4);
            wr_addr     = ($urandom_range(0, 1) != 0) ? A'($urandom_range(0, 3)) : A'($urandom);
            wr_data     = D'($urandom);
            inv_en      = ($urandom_range(0, 9) < 4);
            inv_addr    = ($urandom_range(0, 1) != 0) ? A'($urandom_range(0, 3)) : A'($urandom);
            pc_in       = D'($urandom);
`ifdef PC_TARGET_REL_EN
            wr_rel      = 1'($urandom_range(0, 1));
`else
            wr_rel      = 1'b0;
`endif
            tick();
            $display("rand %0d tv=%0b hit=%0b target=%0h count=%0d", c, target_valid, hit, target, valid_count);
            checks++; if (target_valid !== e_tv || hit !== e_hit || target !== e_target) begin
                failures++; $display("FAIL rand_lookup cyc=%0d got tv=%0b hit=%0b target=%0h exp tv=%0b hit=%0b target=%0h", c, target_valid, hit, target, e_tv, e_hit, e_target);
            end
            checks++; if (valid_count !== (A+1)'(model_count())) begin
                failures++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, valid_count, model_count());
            end
        end
        idle();
    endtask

    task automatic test_reset_midop();
        idle();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 12'd77;
        tick();
        idle();
        lookup_req = 1'b1; lookup_addr = 5'd9;
        tick();
        checks++; if (target_valid !== 1'b1 || hit !== 1'b1 || target !== 12'd77) begin
            failures++; $display("FAIL pre_rst_lookup got tv=%0b hit=%0b target=%0d exp tv=1 hit=1 target=77", target_valid, hit, target);
        end
        #1;
        reset = 1'b1;
        #1;
        $display("mid reset tv=%0b hit=%0b target=%0h count=%0d ready=%0b", target_valid, hit, target, valid_count, ready);
        checks++; if (target_valid !== 1'b0 || hit !== 1'b0 || target !== '0 || valid_count !== '0 || ready !== 1'b0) begin
            failures++; $display("FAIL async_rst got tv=%0b hit=%0b target=%0h count=%0d ready=%0b exp all 0", target_valid, hit, target, valid_count, ready);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        for (int c = 0; c < DEPTH; c++) begin
            lookup_req = 1'b1; lookup_addr = 5'd9;
            tick();
            checks++; if (ready !== m_run || target_valid !== 1'b0) begin
                failures++; $display("FAIL reinit cyc=%0d got ready=%0b tv=%0b exp ready=%0b tv=0", c, ready, target_valid, m_run);
            end
        end
        lookup_req = 1'b1; lookup_addr = 5'd9;
        tick();
        $display("post reinit lookup idx=9 tv=%0b hit=%0b target=%0h", target_valid, hit, target);
        checks++; if (target_valid !== 1'b1 || hit !== 1'b0 || target !== '0) begin
            failures++; $display("FAIL reinit_lookup got tv=%0b hit=%0b target=%0h exp tv=1 hit=0 target=0", target_valid, hit, target);
        end
        idle();
    endtask

`ifdef PC_TARGET_REL_EN
    task automatic test_rel();
        idle();
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 12'hFF0; wr_rel = 1'b1;
        tick();
        idle();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 12'd48; wr_rel = 1'b0;
        tick();
        idle();
        lookup_req = 1'b1; lookup_addr = 5'd2; pc_in = 12'h020;
        tick();
        $display("rel lookup idx=2 target=%0h", target);
        checks++; if (hit !== 1'b1 || target !== 12'h010) begin failures++; $display("FAIL rel_wrap got hit=%0b target=%0h exp hit=1 target=010", hit, target); end
        lookup_addr = 5'd3; pc_in = D'($urandom);
        tick();
        $display("abs lookup idx=3 target=%0d", target);
        checks++; if (hit !== 1'b1 || target !== 12'd48) begin failures++; $display("FAIL rel_abs got hit=%0b target=%0d exp hit=1 target=48", hit, target); end
        idle();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        idle();
        #2;
        test_reset();
        test_write_lookup();
        test_forwarding();
        test_fill_invalidate();
        test_random();
        test_reset_midop();
`ifdef PC_TARGET_REL_EN
        test_rel();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
